// File: rtl/dual_port_ram_clr_pkg.sv
// Shared types and constants for the clearable true dual-port RAM.
package dual_port_ram_pkg;

    typedef enum logic {
        READY = 1'b0,
        CLEAR = 1'b1
    } ram_state_e;

    localparam int unsigned READ_FIRST  = 0;
    localparam int unsigned WRITE_FIRST = 1;

endpackage

// File: rtl/dual_port_ram_clr_if.sv
// Bus bundle for both RAM ports plus the clear/status sideband.
interface dual_port_ram_clr_if #(
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned DATA_WIDTH = 20
);
    logic                  en_a;
    logic                  we_a;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [DATA_WIDTH-1:0] din_a;
    logic [DATA_WIDTH-1:0] dout_a;
    logic                  dout_valid_a;

    logic                  en_b;
    logic                  we_b;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [DATA_WIDTH-1:0] din_b;
    logic [DATA_WIDTH-1:0] dout_b;
    logic                  dout_valid_b;

    logic                  clear_req;
    logic                  busy;
    logic                  collision;

    modport master (
        output en_a, we_a, addr_a, din_a,
        output en_b, we_b, addr_b, din_b,
        output clear_req,
        input  dout_a, dout_valid_a, dout_b, dout_valid_b,
        input  busy, collision
    );

    modport slave (
        input  en_a, we_a, addr_a, din_a,
        input  en_b, we_b, addr_b, din_b,
        input  clear_req,
        output dout_a, dout_valid_a, dout_b, dout_valid_b,
        output busy, collision
    );

endinterface

// File: rtl/dual_port_ram_clr_out_stage.sv
// Per-port read-data/valid register, with an optional second pipeline stage.
module ram_out_stage #(
    parameter int unsigned DATA_WIDTH = 20,
    parameter int unsigned OUT_REG    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  acc_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic [DATA_WIDTH-1:0] dout_o,
    output logic                  valid_o
);

    logic [DATA_WIDTH-1:0] s0_data_q;
    logic                  s0_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_data_q  <= '0;
            s0_valid_q <= 1'b0;
        end else begin
            s0_valid_q <= acc_i;
            if (acc_i) begin
                s0_data_q <= rdata_i;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] s1_data_q;
            logic                  s1_valid_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_data_q  <= '0;
                    s1_valid_q <= 1'b0;
                end else begin
                    s1_valid_q <= s0_valid_q;
                    if (s0_valid_q) begin
                        s1_data_q <= s0_data_q;
                    end
                end
            end

            assign dout_o  = s1_data_q;
            assign valid_o = s1_valid_q;
        end else begin : g_out_direct
            assign dout_o  = s0_data_q;
            assign valid_o = s0_valid_q;
        end
    endgenerate

endmodule

// File: rtl/dual_port_ram_clr.sv
// True dual-port RAM with collision detection, port-A write priority and a clear engine.
module dual_port_ram_clr
    import dual_port_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 7,
    parameter int unsigned MEM_SIZE       = 128,
    parameter int unsigned DATA_WIDTH     = 20,
    parameter int unsigned READ_MODE      = 0,
    parameter int unsigned OUT_REG        = 0,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    dual_port_ram_clr_if.slave  bus
);

    ram_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE];

    logic                  busy;
    logic                  acc_a, acc_b;
    logic                  in_rng_a, in_rng_b;
    logic                  same_addr;
    logic                  wr_a, wr_b;
    logic                  coll_d, coll_q;
    logic [DATA_WIDTH-1:0] rdata_a, rdata_b;

    assign busy = (state_q == CLEAR);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            READY: begin
                if (bus.clear_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (32'(cnt_q) == MEM_SIZE - 1) begin
                    state_d = READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            default: begin
                state_d = READY;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            cnt_q   <= '0;
            coll_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            coll_q  <= coll_d;
        end
    end

    // Port B's write is dropped on an address clash with a port-A write; in write-first
    // mode a dropped write returns the stored word rather than the discarded din_b.
    always_comb begin
        acc_a     = bus.en_a & ~busy;
        acc_b     = bus.en_b & ~busy;
        in_rng_a  = 32'(bus.addr_a) < MEM_SIZE;
        in_rng_b  = 32'(bus.addr_b) < MEM_SIZE;
        same_addr = (bus.addr_a == bus.addr_b);
        wr_a      = acc_a & bus.we_a & in_rng_a;
        wr_b      = acc_b & bus.we_b & in_rng_b & ~(wr_a & same_addr);
        coll_d    = acc_a & acc_b & same_addr & (bus.we_a | bus.we_b);

        rdata_a = '0;
        if (in_rng_a) begin
            rdata_a = (READ_MODE == WRITE_FIRST && wr_a) ? bus.din_a : mem_q[bus.addr_a];
        end
        rdata_b = '0;
        if (in_rng_b) begin
            rdata_b = (READ_MODE == WRITE_FIRST && wr_b) ? bus.din_b : mem_q[bus.addr_b];
        end
    end

    always_ff @(posedge clk) begin
        if (busy) begin
            mem_q[cnt_q] <= '0;
        end else begin
            if (wr_a) begin
                mem_q[bus.addr_a] <= bus.din_a;
            end
            if (wr_b) begin
                mem_q[bus.addr_b] <= bus.din_b;
            end
        end
    end

    assign bus.busy      = busy;
    assign bus.collision = coll_q;

    ram_out_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_REG    (OUT_REG)
    ) u_out_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .acc_i   (acc_a),
        .rdata_i (rdata_a),
        .dout_o  (bus.dout_a),
        .valid_o (bus.dout_valid_a)
    );

    ram_out_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_REG    (OUT_REG)
    ) u_out_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .acc_i   (acc_b),
        .rdata_i (rdata_b),
        .dout_o  (bus.dout_b),
        .valid_o (bus.dout_valid_b)
    );

endmodule

// File: tb/tb_dual_port_ram_clr.sv
// Scoreboard bench: a default-config RAM plus a write-first/registered-output RAM.
module tb_dual_port_ram_clr;

    localparam int unsigned AW = 7;
    localparam int unsigned DW = 20;

    typedef struct {
        logic [DW-1:0] d;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    logic tb_busy;

    logic [DW-1:0] mem_m [128];
    logic [DW-1:0] m1 [128];
    exp_t qa[$];
    exp_t qb[$];
    exp_t q1a[$];
    int   cq[$];
    exp_t ea, eb, e1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dual_port_ram_clr_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    dual_port_ram_clr_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

    dual_port_ram_clr #(
        .ADDR_WIDTH(AW), .MEM_SIZE(128), .DATA_WIDTH(DW),
        .READ_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    dual_port_ram_clr #(
        .ADDR_WIDTH(AW), .MEM_SIZE(128), .DATA_WIDTH(DW),
        .READ_MODE(1), .OUT_REG(1), .CLEAR_ON_RESET(0)
    ) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Drive one cycle on the default RAM; expected reads use the pre-write model contents.
    task automatic step(input logic ea_i, input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                        input logic eb_i, input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
        exp_t e;
        bus.en_a = ea_i; bus.we_a = wa; bus.addr_a = aa; bus.din_a = da;
        bus.en_b = eb_i; bus.we_b = wb; bus.addr_b = ab; bus.din_b = db;
        if (!tb_busy) begin
            if (ea_i) begin
                e.d = mem_m[aa]; e.cyc = cyc + 1; qa.push_back(e);
            end
            if (eb_i) begin
                e.d = mem_m[ab]; e.cyc = cyc + 1; qb.push_back(e);
            end
            if (ea_i && eb_i && aa == ab && (wa || wb)) cq.push_back(cyc + 1);
            if (eb_i && wb) mem_m[ab] = db;
            if (ea_i && wa) mem_m[aa] = da;
        end
        @(posedge clk);
        #1;
        bus1.en_a = 1'b0; bus1.we_a = 1'b0;
    endtask

    task automatic drive1(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        bus1.en_a = 1'b1; bus1.we_a = we; bus1.addr_a = a; bus1.din_a = d;
        e.d = we ? d : m1[a];
        e.cyc = cyc + 2;
        q1a.push_back(e);
        if (we) m1[a] = d;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic wait_busy(input string tag, input logic hold_en_a);
        int n = 0;
        while (bus.busy === 1'b1 && n < 400) begin
            step(hold_en_a, 1'b0, AW'(n), '0, 1'b0, 1'b0, '0, '0);
            n++;
        end
        chk(tag, 32'(n), 32'd128);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            while (qa.size() > 0 && qa[0].cyc < cyc) begin
                void'(qa.pop_front());
                chk("a_valid_missing", 32'd0, 32'd1);
            end
            if (bus.dout_valid_a) begin
                if (qa.size() == 0) chk("a_valid_spurious", 32'd1, 32'd0);
                else begin
                    ea = qa.pop_front();
                    chk("a_data", 32'(bus.dout_a), 32'(ea.d));
                    chk("a_latency", 32'(cyc), 32'(ea.cyc));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            while (qb.size() > 0 && qb[0].cyc < cyc) begin
                void'(qb.pop_front());
                chk("b_valid_missing", 32'd0, 32'd1);
            end
            if (bus.dout_valid_b) begin
                if (qb.size() == 0) chk("b_valid_spurious", 32'd1, 32'd0);
                else begin
                    eb = qb.pop_front();
                    chk("b_data", 32'(bus.dout_b), 32'(eb.d));
                    chk("b_latency", 32'(cyc), 32'(eb.cyc));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            while (q1a.size() > 0 && q1a[0].cyc < cyc) begin
                void'(q1a.pop_front());
                chk("wf_a_valid_missing", 32'd0, 32'd1);
            end
            if (bus1.dout_valid_a) begin
                if (q1a.size() == 0) chk("wf_a_valid_spurious", 32'd1, 32'd0);
                else begin
                    e1 = q1a.pop_front();
                    chk("wf_a_data", 32'(bus1.dout_a), 32'(e1.d));
                    chk("wf_a_latency", 32'(cyc), 32'(e1.cyc));
                end
            end
        end
    end

    always @(negedge clk) begin
        logic exp_coll;
        if (rst_n) begin
            exp_coll = (cq.size() > 0 && cq[0] == cyc);
            if (exp_coll) void'(cq.pop_front());
            chk("collision", 32'(bus.collision), 32'(exp_coll));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic          r_ea, r_wa, r_eb, r_wb;
        logic [AW-1:0] r_aa, r_ab;
        logic [DW-1:0] r_da, r_db;

        rst_n = 1'b0;
        tb_busy = 1'b1;
        bus.clear_req = 1'b0;
        bus1.clear_req = 1'b0;
        bus1.en_a = 1'b0; bus1.we_a = 1'b0; bus1.addr_a = '0; bus1.din_a = '0;
        bus1.en_b = 1'b0; bus1.we_b = 1'b0; bus1.addr_b = '0; bus1.din_b = '0;
        bus.en_a = 1'b0; bus.we_a = 1'b0; bus.addr_a = '0; bus.din_a = '0;
        bus.en_b = 1'b0; bus.we_b = 1'b0; bus.addr_b = '0; bus.din_b = '0;
        for (int i = 0; i < 128; i++) mem_m[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout_a", 32'(bus.dout_a), 32'd0);
        chk("rst_valid_a", 32'(bus.dout_valid_a), 32'd0);
        chk("rst_valid_b", 32'(bus.dout_valid_b), 32'd0);
        chk("rst_collision", 32'(bus.collision), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd1);
        chk("rst_busy_noclear", 32'(bus1.busy), 32'd0);
        rst_n = 1'b1;
        wait_busy("init_busy_cycles", 1'b0);
        tb_busy = 1'b0;

        // Post-clear reads, then same-address dual read (not a collision)
        step(1'b1, 1'b0, 7'd0, '0, 1'b1, 1'b0, 7'd64, '0);
        step(1'b1, 1'b0, 7'd127, '0, 1'b1, 1'b0, 7'd127, '0);

        // Same-port read-during-write: read-first on dut, write-first on dut1
        drive1(1'b1, 7'd5, 20'h12345);
        step(1'b1, 1'b1, 7'd5, 20'h12345, 1'b0, 1'b0, '0, '0);
        drive1(1'b0, 7'd5, '0);
        step(1'b1, 1'b0, 7'd5, '0, 1'b0, 1'b0, '0, '0);

        // Double write to one address: port A wins
        step(1'b1, 1'b1, 7'd9, 20'hAAAAA, 1'b1, 1'b1, 7'd9, 20'h55555);
        step(1'b1, 1'b0, 7'd9, '0, 1'b1, 1'b0, 7'd9, '0);

        // Write on A while B reads the same word: B sees the old word
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 7'd3, 20'h11111);
        step(1'b1, 1'b1, 7'd3, 20'h0F0F0, 1'b1, 1'b0, 7'd3, '0);
        step(1'b1, 1'b0, 7'd3, '0, 1'b1, 1'b0, 7'd3, '0);

        for (int i = 0; i < 40; i++) begin
            r_ea = 1'($urandom_range(0, 1)); r_wa = 1'($urandom_range(0, 1));
            r_eb = 1'($urandom_range(0, 1)); r_wb = 1'($urandom_range(0, 1));
            r_aa = AW'($urandom_range(0, 7)); r_ab = AW'($urandom_range(0, 7));
            r_da = DW'($urandom); r_db = DW'($urandom);
            step(r_ea, r_wa, r_aa, r_da, r_eb, r_wb, r_ab, r_db);
        end

        for (int i = 0; i < 64; i++) begin
            step(1'b1, 1'b1, AW'(2 * i), DW'(i * 4099 + 7), 1'b1, 1'b1, AW'(2 * i + 1), DW'(i * 771 + 3));
        end

        // Clear on request with port A hammering reads the whole time
        bus.clear_req = 1'b1;
        idle();
        bus.clear_req = 1'b0;
        tb_busy = 1'b1;
        wait_busy("req_busy_cycles", 1'b1);
        tb_busy = 1'b0;
        for (int i = 0; i < 128; i++) mem_m[i] = '0;
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 1'b0, AW'(2 * i), '0, 1'b1, 1'b0, AW'(2 * i + 1), '0);
        end

        // Reset landing in the middle of a clear
        step(1'b1, 1'b1, 7'd1, 20'h33333, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, 7'd1, '0, 1'b0, 1'b0, '0, '0);
        idle();
        chk("pre_rst_dout_a", 32'(bus.dout_a), 32'h33333);
        bus.clear_req = 1'b1;
        idle();
        bus.clear_req = 1'b0;
        tb_busy = 1'b1;
        repeat (40) step(1'b1, 1'b0, 7'd1, '0, 1'b0, 1'b0, '0, '0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midclr_rst_dout_a", 32'(bus.dout_a), 32'd0);
        chk("midclr_rst_valid_a", 32'(bus.dout_valid_a), 32'd0);
        chk("midclr_rst_collision", 32'(bus.collision), 32'd0);
        chk("midclr_rst_busy", 32'(bus.busy), 32'd1);
        qa.delete(); qb.delete(); q1a.delete(); cq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_busy("restart_busy_cycles", 1'b0);
        tb_busy = 1'b0;
        for (int i = 0; i < 128; i++) mem_m[i] = '0;
        step(1'b1, 1'b0, 7'd0, '0, 1'b1, 1'b0, 7'd1, '0);
        step(1'b1, 1'b0, 7'd64, '0, 1'b1, 1'b0, 7'd127, '0);

        repeat (4) idle();
        chk("drain_a", 32'(qa.size()), 32'd0);
        chk("drain_b", 32'(qb.size()), 32'd0);
        chk("drain_wf_a", 32'(q1a.size()), 32'd0);
        chk("drain_collision", 32'(cq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dual_port_ram_clr.md
Name: dual_port_ram_clr

Overview:
- Next-generation true dual-port RAM for the Jacobi datapath, such as matrix and rotation-coefficient storage.
- Both ports share one clock.
- Adds the following, all on the same array:
  - selectable same-port read mode;
  - optional output register stage;
  - per-port read-valid flag;
  - address-collision detection with deterministic write priority;
  - built-in clear engine that zeroes the memory after reset or on request.

Parameters:
- ADDR_WIDTH, 7: address width of both ports.
- MEM_SIZE, 128: number of words; must be ≤ 2**ADDR_WIDTH.
- DATA_WIDTH, 20: word width.
- READ_MODE, 0: same-port read-during-write behaviour. 0 = read-first (old data). 1 = write-first (din).
- OUT_REG, 0: 0 gives read latency 1; 1 adds an output register, giving latency 2.
- CLEAR_ON_RESET, 1: 1 runs the clear engine after reset release; 0 makes the RAM ready immediately.

Ports:
- clk, input, 1: single clock for both ports.
- rst_n, input, 1: asynchronous active-low reset.
- en_a, input, 1: port A access request.
- we_a, input, 1: port A write enable; qualified by en_a.
- addr_a, input, ADDR_WIDTH: port A address.
- din_a, input, DATA_WIDTH: port A write data.
- dout_a, output, DATA_WIDTH: port A read data.
- dout_valid_a, output, 1: dout_a holds the data of an accepted access.
- en_b, we_b, addr_b, din_b, dout_b, dout_valid_b: same as port A, for port B.
- clear_req, input, 1: single-cycle pulse that starts a memory clear.
- busy, output, 1: clear in progress; all port requests are ignored.
- collision, output, 1: one-cycle pulse marking a same-address conflict on accepted accesses.

Behaviour:
- Reset (rst_n=0, async):
  - dout_a/b = 0; dout_valid_a/b = 0; collision = 0; clear counter = 0.
  - FSM goes to CLEAR if CLEAR_ON_RESET=1 (busy=1), otherwise to READY (busy=0).
  - Array contents are not reset directly.
- FSM states: READY, CLEAR.
  - READY → CLEAR on clear_req=1; busy rises the next cycle.
  - In CLEAR, each cycle writes 0 to ram[cnt] and increments cnt.
  - When cnt = MEM_SIZE-1 is written, the FSM returns to READY and cnt returns to 0.
  - busy is high for exactly MEM_SIZE cycles.
  - clear_req is ignored while in CLEAR.
  - rst_n asserted mid-clear restarts from address 0 (when CLEAR_ON_RESET=1) or aborts to READY (when 0).
- Access acceptance: an access on port X is accepted when en_X=1 and busy=0.
  - Unaccepted cycles leave the array and dout_X unchanged.
- Write: an accepted access with we_X=1 and addr_X < MEM_SIZE writes din_X on that clock edge.
  - Out-of-range addresses never write.
- Read: every accepted access (read or write) produces read data.
  - OUT_REG=0: dout_X is updated on the accepting edge. dout_valid_X=1 during the following cycle, 0 otherwise.
  - OUT_REG=1: one extra cycle of delay for both dout_X and dout_valid_X.
  - dout_X holds its last value when not valid.
  - An out-of-range read returns 0, with valid asserted normally.
- Same-port read during write:
  - READ_MODE=0 returns the pre-write word.
  - READ_MODE=1 returns din_X.
- Collision: both ports accepted, addr_a == addr_b, and at least one write.
  - collision=1 during the next cycle.
  - If both ports write, port A's data is stored and port B's write is dropped.
  - If one port writes, the reading port on the other side returns the pre-write word (read-first across ports), independent of READ_MODE.
  - Two reads to the same address are not a collision.
- No combinational path from any input to any output.

Decomposition:
- Package dual_port_ram_pkg:
  - typedef for the FSM state enum {READY, CLEAR};
  - localparams READ_FIRST=0, WRITE_FIRST=1.
- Sub-module ram_out_stage:
  - parametrised by DATA_WIDTH and OUT_REG;
  - holds dout/valid registering with async reset;
  - instantiated once per port.
- The array, write-arbitration logic and clear FSM live in the top module.

Test Plan:
- Reset release with CLEAR_ON_RESET=1, MEM_SIZE=128 → busy high for exactly 128 cycles. Afterwards, reads of addresses 0, 64 and 127 return 0x00000 with valid one cycle later.
- Port A writes 0x12345 to address 5 with READ_MODE=0, then again with READ_MODE=1 → same-cycle dout_a shows the prior word (0) in the first case and 0x12345 in the second. With OUT_REG=1, valid appears 2 cycles after the request.
- Same-cycle writes to address 9, A=0xAAAAA and B=0x55555 → collision pulses for 1 cycle. A subsequent read on either port returns 0xAAAAA.
- Port A writes 0x0F0F0 to address 3 while port B reads address 3 (old value 0x11111) → dout_b = 0x11111 and collision pulses. The next read returns 0x0F0F0.
- clear_req after filling the memory, with en_a held high during the clear → no accesses are accepted, dout_valid_a stays 0, and all words read back 0 afterwards.
- rst_n asserted mid-clear at cnt=40 → outputs return to their reset values asynchronously. The clear restarts and busy lasts a full 128 cycles after release.
